// File: rtl/mem_access_unit_if.sv
// Pipeline-side and data-memory-side signals of the MEM-stage access unit.
// master = the access unit; slave = the pipeline/memory environment around it.
interface mem_access_unit_if;
  // pipeline (EX/MEM -> MEM/WB)
  logic [2:0]  MEM_READ;
  logic [1:0]  MEM_WRITE;
  logic [31:0] ADDRESS;
  logic [31:0] WRITE_DATA;
  logic [31:0] DATA_READED;
  logic        BUSY_WAIT;
  logic        MISALIGNED;
  logic        MEM_ERROR;
  // data memory
  logic [29:0] MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic [3:0]  MEM_BYTE_EN;
  logic        MEM_RD;
  logic        MEM_WR;
  logic [31:0] MEM_RDATA;
  logic        MEM_READY;

  modport master (
    input  MEM_READ, MEM_WRITE, ADDRESS, WRITE_DATA, MEM_RDATA, MEM_READY,
    output DATA_READED, BUSY_WAIT, MISALIGNED, MEM_ERROR,
           MEM_ADDR, MEM_WDATA, MEM_BYTE_EN, MEM_RD, MEM_WR
  );

  modport slave (
    output MEM_READ, MEM_WRITE, ADDRESS, WRITE_DATA, MEM_RDATA, MEM_READY,
    input  DATA_READED, BUSY_WAIT, MISALIGNED, MEM_ERROR,
           MEM_ADDR, MEM_WDATA, MEM_BYTE_EN, MEM_RD, MEM_WR
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory controller: word-aligned load/store with byte lanes and load extension.
// Latency: 1 IDLE + >=1 ACCESS + 1 DONE cycle; BUSY_WAIT stalls the pipeline until memory completes.
// Backpressure: holds strobes until MEM_READY (or TIMEOUT abort); inputs ignored outside IDLE.
module mem_access_unit #(
  parameter int TIMEOUT = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  mem_access_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t        state, state_nxt;
  logic [CW-1:0] tmr;
  logic          is_load;
  logic [2:0]    ld_type;
  logic [1:0]    a_lo;

  logic          rd_req, wr_req, req, mis, timed_out;
  logic [1:0]    a_eff;
  logic [31:0]   st_wdata;
  logic [3:0]    st_be;

  function automatic logic [31:0] extend(input logic [2:0] t, input logic [1:0] a,
                                         input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (t)
      3'b001:  return {{24{b[7]}}, b};
      3'b010:  return {{16{h[15]}}, h};
      3'b100:  return {24'b0, b};
      3'b101:  return {16'b0, h};
      default: return w;
    endcase
  endfunction

  always_comb begin
    rd_req = (bus.MEM_READ != 3'b000) && (bus.MEM_READ <= 3'b101);
    // a simultaneous write is dropped when a read is requested
    wr_req = !rd_req && (bus.MEM_WRITE != 2'b00);
    req    = rd_req || wr_req;

    mis = 1'b0;
    if (rd_req) begin
      case (bus.MEM_READ)
        3'b010, 3'b101: mis = bus.ADDRESS[0];
        3'b011:         mis = |bus.ADDRESS[1:0];
        default:        mis = 1'b0;
      endcase
    end else if (wr_req) begin
      case (bus.MEM_WRITE)
        2'b10:   mis = bus.ADDRESS[0];
        2'b11:   mis = |bus.ADDRESS[1:0];
        default: mis = 1'b0;
      endcase
    end
    a_eff = mis ? 2'b00 : bus.ADDRESS[1:0];

    st_wdata = bus.WRITE_DATA;
    st_be    = 4'b1111;
    case (bus.MEM_WRITE)
      2'b01: begin
        st_wdata = {4{bus.WRITE_DATA[7:0]}};
        st_be    = 4'b0001 << a_eff;
      end
      2'b10: begin
        st_wdata = {2{bus.WRITE_DATA[15:0]}};
        st_be    = a_eff[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase

    timed_out = (TIMEOUT != 0) && (tmr == CW'(TIMEOUT - 1)) && !bus.MEM_READY;

    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = ACCESS;
      ACCESS:  if (bus.MEM_READY || timed_out) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // gated by RESET so an in-flight stall releases the moment reset hits
  assign bus.BUSY_WAIT = !RESET && ((state == IDLE && req) || state == ACCESS);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tmr             <= '0;
      is_load         <= 1'b0;
      ld_type         <= 3'b000;
      a_lo            <= 2'b00;
      bus.DATA_READED <= '0;
      bus.MISALIGNED  <= 1'b0;
      bus.MEM_ERROR   <= 1'b0;
      bus.MEM_ADDR    <= '0;
      bus.MEM_WDATA   <= '0;
      bus.MEM_BYTE_EN <= '0;
      bus.MEM_RD      <= 1'b0;
      bus.MEM_WR      <= 1'b0;
    end else begin
      bus.MISALIGNED <= 1'b0;
      bus.MEM_ERROR  <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            tmr             <= '0;
            is_load         <= rd_req;
            ld_type         <= rd_req ? bus.MEM_READ : 3'b000;
            a_lo            <= a_eff;
            bus.MEM_ADDR    <= bus.ADDRESS[31:2];
            bus.MEM_WDATA   <= rd_req ? 32'h0 : st_wdata;
            bus.MEM_BYTE_EN <= rd_req ? 4'b0000 : st_be;
            bus.MEM_RD      <= rd_req;
            bus.MEM_WR      <= !rd_req;
            bus.MISALIGNED  <= mis;
          end
        end
        ACCESS: begin
          if (bus.MEM_READY) begin
            if (is_load) bus.DATA_READED <= extend(ld_type, a_lo, bus.MEM_RDATA);
            bus.MEM_RD <= 1'b0;
            bus.MEM_WR <= 1'b0;
          end else if (timed_out) begin
            bus.MEM_RD    <= 1'b0;
            bus.MEM_WR    <= 1'b0;
            bus.MEM_ERROR <= 1'b1;
          end else begin
            tmr <= tmr + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed + random loads/stores against an arithmetic model.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic CLK;
  logic RESET;

  mem_access_unit_if bus();

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  typedef struct {
    logic [29:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        mis;
    logic        err;
    logic [31:0] dr;
    int          busy;
  } exp_t;

  exp_t        q[$];
  int          checks;
  int          passes;
  logic [31:0] exp_dr;
  int          cur_delay;
  bit          resp_en;
  bit          mon_en;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name, input string what);
    checks++;
    $display("FAIL %s: %s", name, what);
  endtask

  // memory model: READY in the (cur_delay+1)-th cycle a strobe is seen
  initial begin
    int n;
    n = 0;
    bus.MEM_READY = 1'b0;
    forever begin
      @(negedge CLK);
      if (!resp_en) begin
        n = 0;
      end else if (bus.MEM_RD || bus.MEM_WR) begin
        bus.MEM_READY = (n == cur_delay);
        n++;
      end else begin
        bus.MEM_READY = 1'b0;
        n = 0;
      end
    end
  end

  // monitor: checks access fields when strobes rise, results when the stall releases
  initial begin
    bit   prev_busy, prev_strb, strb;
    int   busy_cnt;
    exp_t e;
    prev_busy = 0; prev_strb = 0; busy_cnt = 0;
    forever begin
      @(negedge CLK);
      if (!mon_en) begin
        prev_busy = 0; prev_strb = 0; busy_cnt = 0;
      end else begin
        strb = bus.MEM_RD || bus.MEM_WR;
        if (strb && !prev_strb) begin
          if (q.size() == 0) fail_now("unexpected_access", "got strobe, expected no pending request");
          else begin
            e = q[0];
            check("mem_addr", bus.MEM_ADDR, e.addr);
            check("mem_rd", bus.MEM_RD, e.rd);
            check("mem_wr", bus.MEM_WR, e.wr);
            check("byte_en", bus.MEM_BYTE_EN, e.be);
            check("misaligned", bus.MISALIGNED, e.mis);
            if (e.wr) check("mem_wdata", bus.MEM_WDATA, e.wdata);
          end
        end
        if (bus.BUSY_WAIT) busy_cnt++;
        if (!bus.BUSY_WAIT && prev_busy) begin
          if (q.size() == 0) fail_now("unexpected_done", "got stall release, expected no pending request");
          else begin
            e = q.pop_front();
            check("data_readed", bus.DATA_READED, e.dr);
            check("mem_error", bus.MEM_ERROR, e.err);
            check("done_strobes", {30'b0, bus.MEM_RD, bus.MEM_WR}, 32'h0);
            check("mis_pulse_len", bus.MISALIGNED, 1'b0);
            check("busy_cycles", busy_cnt, e.busy);
          end
          busy_cnt = 0;
        end
        prev_busy = bus.BUSY_WAIT;
        prev_strb = strb;
      end
    end
  end

  task automatic issue(input logic [2:0] rd_t, input logic [1:0] wr_t, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rdata, input int d);
    exp_t        e;
    logic [31:0] sz, off, ea, v;
    bit          is_ld, sgn;
    int          k;
    is_ld = (rd_t >= 3'd1) && (rd_t <= 3'd5);
    sgn   = (rd_t == 3'd1) || (rd_t == 3'd2);
    if (is_ld) sz = (rd_t == 3'd3) ? 4 : ((rd_t == 3'd2 || rd_t == 3'd5) ? 2 : 1);
    else       sz = (wr_t == 2'd3) ? 4 : ((wr_t == 2'd2) ? 2 : 1);
    e.mis   = (addr % sz) != 0;
    ea      = e.mis ? addr - (addr % 4) : addr;
    off     = ea % 4;
    e.addr  = 30'(ea / 4);
    e.rd    = is_ld;
    e.wr    = !is_ld;
    e.be    = is_ld ? 4'b0000 : 4'(((32'd1 << sz) - 1) << off);
    e.wdata = (sz == 1) ? (wd % 256) * 32'h0101_0101 :
              (sz == 2) ? (wd % 65536) * 32'h0001_0001 : wd;
    e.err   = d >= TO;
    e.busy  = 1 + (e.err ? TO : d + 1);
    if (is_ld && !e.err) begin
      v = rdata >> (8 * off);
      if (sz < 4) begin
        v = v % (32'd1 << (8 * sz));
        if (sgn && v >= (32'd1 << (8 * sz - 1))) v = v - (32'd1 << (8 * sz));
      end
      exp_dr = v;
    end
    e.dr = exp_dr;

    @(posedge CLK); #1;
    cur_delay      = d;
    bus.MEM_RDATA  = rdata;
    bus.MEM_READ   = rd_t;
    bus.MEM_WRITE  = wr_t;
    bus.ADDRESS    = addr;
    bus.WRITE_DATA = wd;
    q.push_back(e);
    k = 0;
    do begin
      @(posedge CLK); #1;
      k++;
    end while (bus.BUSY_WAIT && k < 30);
    if (bus.BUSY_WAIT) fail_now("done_timeout", "got BUSY_WAIT stuck high, expected release");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      bus.MEM_READ  = 3'b000;
      bus.MEM_WRITE = 2'b00;
      #1;
      check("idle_busy", bus.BUSY_WAIT, 1'b0);
    end
  endtask

  initial begin
    logic [2:0]  rd;
    logic [1:0]  wr;
    logic [31:0] addr;
    int          kind;
    checks = 0; passes = 0; exp_dr = 0; cur_delay = 0; resp_en = 1; mon_en = 1;
    RESET = 1'b1;
    bus.MEM_READ = 0; bus.MEM_WRITE = 0; bus.ADDRESS = 0; bus.WRITE_DATA = 0; bus.MEM_RDATA = 0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_busy", bus.BUSY_WAIT, 1'b0);
    check("rst_rd_wr", {30'b0, bus.MEM_RD, bus.MEM_WR}, 32'h0);
    check("rst_pulses", {30'b0, bus.MISALIGNED, bus.MEM_ERROR}, 32'h0);
    check("rst_data_readed", bus.DATA_READED, 32'h0);
    check("rst_mem_addr", bus.MEM_ADDR, 32'h0);
    check("rst_wdata", bus.MEM_WDATA, 32'h0);
    check("rst_byte_en", bus.MEM_BYTE_EN, 32'h0);
    @(negedge CLK);
    RESET = 1'b0;
    idle(2);

    issue(3'd3, 2'd0, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 2);
    issue(3'd1, 2'd0, 32'h0000_0103, 32'h0, 32'h80FF_FF12, 0);
    issue(3'd4, 2'd0, 32'h0000_0103, 32'h0, 32'h80FF_FF12, 0);
    issue(3'd0, 2'd2, 32'h0000_0022, 32'h1234_ABCD, 32'h0, 1);
    issue(3'd3, 2'd0, 32'h0000_0101, 32'h0, 32'h1122_3344, 0);
    issue(3'd0, 2'd1, 32'h0000_0007, 32'h0000_00A5, 32'h0, 0);
    issue(3'd3, 2'd3, 32'h0000_0040, 32'h0000_FFFF, 32'h0000_0055, 0);
    issue(3'd0, 2'd3, 32'h0000_0080, 32'h0000_0001, 32'h0, 7);
    issue(3'd2, 2'd0, 32'h0000_0012, 32'h0, 32'h8001_7FFE, 3);
    issue(3'd5, 2'd0, 32'h0000_0013, 32'h0, 32'h8001_7FFE, 4);
    issue(3'd7, 2'd1, 32'h0000_0011, 32'h0000_0033, 32'h0, 0);
    idle(1);

    for (int i = 0; i < 60; i++) begin
      kind = int'($urandom_range(0, 3));
      rd   = (kind == 0 || kind == 2) ? 3'($urandom_range(1, 5)) :
             (kind == 3) ? 3'($urandom_range(6, 7)) : 3'd0;
      wr   = (kind == 0) ? 2'd0 : 2'($urandom_range(1, 3));
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      issue(rd, wr, addr, $urandom, $urandom, int'($urandom_range(0, 5)));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end

    issue(3'd3, 2'd0, 32'h0000_0300, 32'h0, 32'hDEAD_BEEF, 0);
    @(negedge CLK); #1;
    check("queue_drained", q.size(), 32'h0);
    check("dr_before_reset", bus.DATA_READED, exp_dr);

    mon_en  = 0;
    resp_en = 0;
    bus.MEM_READY = 1'b0;
    @(posedge CLK); #1;
    bus.MEM_READ = 3'd3;
    bus.ADDRESS  = 32'h0000_0200;
    @(posedge CLK); #1;
    check("midrst_rd_before", bus.MEM_RD, 1'b1);
    RESET = 1'b1;
    #1;
    check("midrst_rd", bus.MEM_RD, 1'b0);
    check("midrst_busy", bus.BUSY_WAIT, 1'b0);
    check("midrst_data_readed", bus.DATA_READED, 32'h0);
    check("midrst_mem_addr", bus.MEM_ADDR, 32'h0);
    @(negedge CLK);
    bus.MEM_READ  = 3'd0;
    bus.MEM_RDATA = 32'h1234_5678;
    RESET         = 1'b0;
    bus.MEM_READY = 1'b1;
    @(posedge CLK); #1;
    bus.MEM_READY = 1'b0;
    check("late_ready_busy", bus.BUSY_WAIT, 1'b0);
    check("late_ready_rd", bus.MEM_RD, 1'b0);
    check("late_ready_dr", bus.DATA_READED, 32'h0);
    @(posedge CLK); #1;
    check("late_ready_dr2", bus.DATA_READED, 32'h0);
    check("late_ready_err", bus.MEM_ERROR, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
